// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: continuous, one-shot or burst runs of
// period/width-shaped pulses with a per-run completed-period counter.
module pulse_train_gen #(
  parameter int unsigned CNT_W   = 25,
  parameter int unsigned BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst_signal,
  input  logic               en,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   width,
  input  logic [BURST_W-1:0] burst_len,
  output logic               pulse,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] pulse_cnt
);

  localparam logic [1:0] MODE_ONE   = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   phase_q, phase_nxt;
  logic [BURST_W-1:0] cnt_q, cnt_nxt;
  logic               pulse_nxt, busy_nxt, done_nxt, latch_en;
  logic [CNT_W-1:0]   period_q, width_q;
  logic [BURST_W-1:0] burst_q;
  logic [1:0]         mode_q;
  logic               start_ok_c;
  logic [CNT_W-1:0]   phase_inc;
  logic [BURST_W-1:0] cnt_inc;

  // A launch is only legal with a usable configuration.
  assign start_ok_c = start && en && (mode != MODE_RSVD) && (period != '0) &&
                      ((mode != MODE_BURST) || (burst_len != '0));
  assign phase_inc  = phase_q + CNT_W'(1);
  assign cnt_inc    = cnt_q + BURST_W'(1);

  // State register and run datapath.
  always_ff @(posedge clk or posedge rst_signal) begin
    if (rst_signal) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      cnt_q     <= '0;
      pulse     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      period_q  <= '0;
      width_q   <= '0;
      burst_q   <= '0;
      mode_q    <= '0;
    end else begin
      state_q   <= state_nxt;
      phase_q   <= phase_nxt;
      cnt_q     <= cnt_nxt;
      pulse     <= pulse_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      if (latch_en) begin
        period_q <= period;
        width_q  <= width;
        burst_q  <= burst_len;
        mode_q   <= mode;
      end
    end
  end

  assign pulse_cnt = cnt_q;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state_q;
    phase_nxt = phase_q;
    cnt_nxt   = cnt_q;
    pulse_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    latch_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ok_c) begin
          state_nxt = RUN;
          phase_nxt = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          pulse_nxt = (width != '0);
          latch_en  = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
          phase_nxt = '0;
        end else if (phase_q == period_q - CNT_W'(1)) begin
          // End of a period: count it, then finish or start the next one.
          phase_nxt = '0;
          cnt_nxt   = cnt_inc;
          if ((mode_q == MODE_ONE) ||
              ((mode_q == MODE_BURST) && (cnt_inc == burst_q))) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            busy_nxt  = 1'b1;
            pulse_nxt = (width_q != '0);
          end
        end else begin
          phase_nxt = phase_inc;
          busy_nxt  = 1'b1;
          pulse_nxt = (phase_inc < width_q);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
